mem_access_unit: RTL and testbench



---
 rtl/mem_pkg.sv | 47 ++++
 rtl/load_extend.sv | 31 +++
 rtl/mem_access_unit.sv | 127 ++++++++++++
 tb/tb_mem_access_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared op codes, state encoding and lane constants
// for the MEM-stage load/store engine.
package mem_pkg;

  localparam logic [2:0] OP_WORD  = 3'd0;
  localparam logic [2:0] OP_HALF  = 3'd1;
  localparam logic [2:0] OP_HALFU = 3'd2;
  localparam logic [2:0] OP_BYTE  = 3'd3;
  localparam logic [2:0] OP_BYTEU = 3'd4;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } size_e;

  // Codes 5-7 fall back to a full-word access.
  function automatic size_e op_size(input logic [2:0] op);
    case (op)
      OP_HALF, OP_HALFU: op_size = SZ_HALF;
      OP_BYTE, OP_BYTEU: op_size = SZ_BYTE;
      default:           op_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [2:0] op,
    input logic [1:0] off
  );
    case (op_size(op))
      SZ_HALF: misaligned = off[0];
      SZ_BYTE: misaligned = 1'b0;
      default: misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half out of a read word
// and sign- or zero-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_word >> {i_off, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_op)
      OP_HALF:  o_data = {{16{w_half[15]}}, w_half};
      OP_HALFU: o_data = {16'h0, w_half};
      OP_BYTE:  o_data = {{24{w_byte[7]}}, w_byte};
      OP_BYTEU: o_data = {24'h0, w_byte};
      default:  o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: req/ack data bus,
// pipeline stall, store lane alignment, load extension.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_wr,
  input  logic        mem_rd,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [1:0]       r_off;

  logic        w_access;
  logic        w_mis;
  logic        w_start;
  logic        w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  assign w_access = mem_wr | mem_rd;
  assign w_mis    = misaligned(mem_op, addr[1:0]);
  assign w_start  = (r_state == S_IDLE) && w_access && !w_mis;
  assign w_tmo    = r_cnt == CNT_W'(TIMEOUT - 1);
  assign stall    = (r_state == S_REQ) || w_start;

  always_comb begin
    w_be    = BE_WORD;
    w_wdata = wdata;
    case (op_size(mem_op))
      SZ_HALF: begin
        w_be    = BE_HALF << addr[1:0];
        w_wdata = {2{wdata[15:0]}};
      end
      SZ_BYTE: begin
        w_be    = BE_BYTE << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  load_extend u_ext (
    .i_op   (r_op),
    .i_off  (r_off),
    .i_word (bus_rdata),
    .o_data (w_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_off     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access && w_mis) begin
            addr_err <= 1'b1;
          end else if (w_start) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_wr;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= w_be;
            bus_wdata <= w_wdata;
            r_op      <= mem_op;
            r_off     <= addr[1:0];
            r_cnt     <= '0;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          // An ack in the last allowed cycle still completes.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) rdata <= w_ext;
            r_state <= S_DONE;
          end else if (w_tmo) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            rdata   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit against a
// transaction-level model of the bus/stall behaviour.
module tb_mem_access_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_wr, mem_rd;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] rdata;
  logic        addr_err, bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic        chk_en;
  logic        e_stall, e_req, e_we, e_aerr, e_berr, e_rchk;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_be;

  mem_access_unit #(.TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_op    (mem_op),
    .addr      (addr),
    .wdata     (wdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .stall     (stall),
    .rdata     (rdata),
    .addr_err  (addr_err),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int sz(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 2;
    if (op == 3'd3 || op == 3'd4) return 1;
    return 4;
  endfunction

  function automatic logic bad_align(input logic [2:0] op,
                                     input logic [31:0] a);
    return (a % sz(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op,
                                      input logic [31:0] a);
    int o;
    o = a % 4;
    if (sz(op) == 2) return 4'(3 * (1 << o));
    if (sz(op) == 1) return 4'(1 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] op,
                                       input logic [31:0] d);
    if (sz(op) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    if (sz(op) == 1) return (d & 32'hFF) * 32'h0101_0101;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * (a % 4));
    case (op)
      3'd1: begin
        v = v & 32'hFFFF;
        if (v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      3'd2: v = v & 32'hFFFF;
      3'd3: begin
        v = v & 32'hFF;
        if (v >= 32'h80) v = v + 32'hFFFF_FF00;
      end
      3'd4: v = v & 32'hFF;
      default: v = w;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall, e_stall);
      chk("bus_req", bus_req, e_req);
      chk("addr_err", addr_err, e_aerr);
      chk("bus_err", bus_err, e_berr);
      if (e_req) begin
        chk("bus_we", bus_we, e_we);
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_be", bus_be, e_be);
        chk("bus_wdata", bus_wdata, e_wdata);
      end
      if (e_rchk) chk("rdata", rdata, e_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_stall = 1'b0;
    e_req   = 1'b0;
    e_aerr  = 1'b0;
    e_berr  = 1'b0;
    e_rchk  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_wr    = 1'b0;
      mem_rd    = 1'b0;
      bus_ack   = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
      set_idle();
      step();
    end
  endtask

  // dly: ack in REQ cycle dly; 0 or >TMO means no ack.
  task automatic do_access(input logic wr, input logic rd,
                           input logic [2:0] op,
                           input logic [31:0] a,
                           input logic [31:0] wd,
                           input int dly,
                           input logic [31:0] rw);
    logic tmo;
    int   n;
    mem_wr  = wr;
    mem_rd  = rd;
    mem_op  = op;
    addr    = a;
    wdata   = wd;
    bus_ack = 1'b0;
    set_idle();
    if (bad_align(op, a)) begin
      step();
      mem_wr  = 1'b0;
      mem_rd  = 1'b0;
      e_aerr  = 1'b1;
      step();
      e_aerr  = 1'b0;
      return;
    end
    e_stall = 1'b1;
    e_we    = wr;
    e_addr  = a & 32'hFFFF_FFFC;
    e_be    = m_be(op, a);
    e_wdata = m_wd(op, wd);
    tmo = (dly == 0) || (dly > TMO);
    n   = tmo ? TMO : dly;
    for (int k = 1; k <= n; k++) begin
      step();
      e_req     = 1'b1;
      bus_ack   = !tmo && (k == n);
      bus_rdata = bus_ack ? rw : $urandom;
    end
    step();
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    e_req   = 1'b0;
    e_stall = 1'b0;
    e_berr  = tmo;
    if (tmo) e_rdata = 32'h0;
    else if (!wr) e_rdata = m_ld(op, a, rw);
    e_rchk  = 1'b1;
    step();
    mem_wr  = 1'b0;
    mem_rd  = 1'b0;
    bus_ack = 1'b0;
    set_idle();
  endtask

  logic twr, trd;
  int   tsel, tdly;

  initial begin
    reset     = 1'b1;
    chk_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_op    = 3'd0;
    addr      = 32'h0;
    wdata     = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    e_rdata   = 32'h0;
    e_we      = 1'b0;
    e_addr    = 32'h0;
    e_be      = 4'h0;
    e_wdata   = 32'h0;
    set_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", bus_req, 1'b0);
    chk("rst_we", bus_we, 1'b0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", bus_be, 4'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_aerr", addr_err, 1'b0);
    chk("rst_berr", bus_err, 1'b0);
    reset  = 1'b0;
    chk_en = 1'b1;
    step();

    chk("pin_lb", m_ld(3'd3, 32'h203, 32'h80FF7F01), 32'hFFFFFF80);
    chk("pin_lbu", m_ld(3'd4, 32'h203, 32'h80FF7F01), 32'h00000080);
    chk("pin_lh", m_ld(3'd1, 32'h302, 32'h80011234), 32'hFFFF8001);
    chk("pin_sh_be", m_be(3'd1, 32'h302), 4'b1100);
    chk("pin_sh_wd", m_wd(3'd1, 32'h0000ABCD), 32'hABCDABCD);

    do_access(1, 0, 3'd0, 32'h104, 32'hDEADBEEF, 3, 32'h0);
    do_access(0, 1, 3'd3, 32'h203, 32'h0, 2, 32'h80FF7F01);
    do_access(0, 1, 3'd4, 32'h203, 32'h0, 1, 32'h80FF7F01);
    do_access(1, 0, 3'd1, 32'h302, 32'h0000ABCD, 2, 32'h0);
    do_access(0, 1, 3'd1, 32'h302, 32'h0, 4, 32'h80011234);
    do_access(0, 1, 3'd0, 32'h101, 32'h0, 1, 32'h0);
    idle_cycles(2);
    do_access(0, 1, 3'd0, 32'h10, 32'h0, 0, 32'h0);
    do_access(1, 0, 3'd0, 32'h14, 32'h12345678, 1, 32'h0);
    do_access(1, 1, 3'd2, 32'h22, 32'h1234, 1, 32'h55AA55AA);
    do_access(0, 1, 3'd0, 32'h30, 32'h0, TMO, 32'hCAFEF00D);
    do_access(0, 1, 3'd0, 32'h30, 32'h0, TMO + 1, 32'h1);
    do_access(0, 1, 3'd6, 32'h3C, 32'h0, 2, 32'h01234567);

    // reset while a request is outstanding, then a late ack
    mem_wr  = 1'b1;
    mem_op  = 3'd0;
    addr    = 32'h40;
    wdata   = 32'hA5A5A5A5;
    set_idle();
    e_stall = 1'b1;
    e_we    = 1'b1;
    e_addr  = 32'h40;
    e_be    = 4'hF;
    e_wdata = 32'hA5A5A5A5;
    step();
    e_req = 1'b1;
    step();
    #2;
    chk_en = 1'b0;
    reset  = 1'b1;
    mem_wr = 1'b0;
    #1;
    chk("mid_rst_req", bus_req, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_addr", bus_addr, 32'h0);
    step();
    reset     = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("late_ack_req", bus_req, 1'b0);
    chk("late_ack_stall", stall, 1'b0);
    chk("late_ack_rdata", rdata, 32'h0);
    chk("late_ack_be", bus_be, 4'h0);
    chk("late_ack_wd", bus_wdata, 32'h0);
    step();
    bus_ack = 1'b0;
    e_rdata = 32'h0;
    set_idle();
    chk_en  = 1'b1;
    step();
    do_access(1, 0, 3'd0, 32'h44, 32'h0BADF00D, 2, 32'h0);

    for (int t = 0; t < 80; t++) begin
      twr  = 1'($urandom_range(0, 1));
      trd  = twr ? 1'($urandom_range(0, 1)) : 1'b1;
      tsel = $urandom_range(0, 19);
      if (tsel == 0) tdly = 0;
      else if (tsel == 1) tdly = TMO;
      else tdly = $urandom_range(1, 4);
      do_access(twr, trd, 3'($urandom_range(0, 7)),
                $urandom, $urandom, tdly, $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
